axi_read_path_ctrl: RTL and testbench

- Read-channel datapath and burst sequencer directly downstream of the read arbiter.
- Consumes the arbiter's grant code, drives the AR channel to the selected slave, and routes the R burst back to the granting master.
- Serves an internal DECERR responder for unmapped addresses.
- Holds the route until the last beat completes, which is the event that returns the arbiter to IDLE.

---
 rtl/axi_rd_pkg.sv | 53 +++++
 rtl/axi_rd_decerr_slave.sv | 44 ++++
 rtl/axi_read_path_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_axi_read_path_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_rd_pkg.sv
// Shared definitions for the AXI read path: grant-code encoding, FSM states,
// response codes and the grant decoder.
package axi_rd_pkg;

  // Grant code from the read arbiter: {master[1:0], slave_field[3:0]}.
  // slave_field 0..7 selects a mapped slave, 4'hF means no slave (unmapped),
  // and the all-ones code means the arbiter has nothing granted.
  localparam int MX_SX_ID_BITS = 6;
  localparam int AR_M_BITS     = 2;
  localparam int AR_SF_BITS    = 4;
  localparam int AR_S_BITS     = 3;
  localparam int AR_NUM_SLAVES = 8;

  localparam logic [MX_SX_ID_BITS-1:0] AR_DEFAULT_R = 6'h3F;
  localparam logic [AR_SF_BITS-1:0]    AR_SLAVE_NO  = 4'hF;

  // Slave indices, for readability at call sites.
  localparam logic [AR_S_BITS-1:0] S_ROM   = 3'd0;
  localparam logic [AR_S_BITS-1:0] S_IM    = 3'd1;
  localparam logic [AR_S_BITS-1:0] S_DM    = 3'd2;
  localparam logic [AR_S_BITS-1:0] S_SCTRL = 3'd3;
  localparam logic [AR_S_BITS-1:0] S_WDT   = 3'd4;
  localparam logic [AR_S_BITS-1:0] S_DRAM  = 3'd5;
  localparam logic [AR_S_BITS-1:0] S_EPU   = 3'd6;
  localparam logic [AR_S_BITS-1:0] S_DMA   = 3'd7;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_DATA     = 3'd2,
    ST_ERR_ADDR = 3'd3,
    ST_ERR_DATA = 3'd4
  } rd_state_e;

  typedef struct packed {
    logic [AR_M_BITS-1:0] master;
    logic [AR_S_BITS-1:0] slave;
    logic                 hit;
  } ar_grant_t;

  // Split a grant code into master index, slave index and a mapped-slave flag.
  function automatic ar_grant_t ar_decode(input logic [MX_SX_ID_BITS-1:0] code);
    ar_grant_t g;
    g.master = code[MX_SX_ID_BITS-1 -: AR_M_BITS];
    g.slave  = code[AR_S_BITS-1:0];
    g.hit    = (code[AR_SF_BITS-1:0] < AR_SF_BITS'(AR_NUM_SLAVES));
    return g;
  endfunction

endpackage

// File: rtl/axi_rd_decerr_slave.sv
// Internal DECERR responder: produces ARLEN+1 error beats for an unmapped
// read, advancing only when the granted master accepts a beat.
module axi_rd_decerr_slave
  import axi_rd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_active,
  input  logic [3:0]  i_len,
  input  logic        i_rready,
  output logic        o_rvalid,
  output logic        o_rlast,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp
);

  logic [3:0] r_cnt;
  logic       w_last;

  assign w_last   = (r_cnt == i_len);
  assign o_rvalid = i_active;
  assign o_rlast  = i_active && w_last;
  assign o_done   = i_active && w_last && i_rready;
  assign o_rdata  = '0;
  assign o_rresp  = i_active ? RESP_DECERR : RESP_OKAY;

  // Beat counter: cleared while the error address phase runs, then counts
  // accepted beats; it holds on the final beat so ARLEN=15 never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values; blocking here would create order-dependent
    // simulation and a mismatch against the synthesized netlist.
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= '0;
    end else if (i_active && i_rready && !w_last) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/axi_read_path_ctrl.sv
// Read-channel sequencer behind the read arbiter: latches the grant, drives
// the AR channel to the selected slave (or the DECERR responder) and routes
// the R burst back to the granting master until its last beat.
module axi_read_path_ctrl
  import axi_rd_pkg::*;
#(
  parameter int NM  = 3,
  parameter int NS  = 8,
  parameter int IDW = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [MX_SX_ID_BITS-1:0] AR_arbiter,
  input  logic [NM*32-1:0]         ARADDR_M,
  input  logic [NM*4-1:0]          ARLEN_M,
  input  logic [NM*IDW-1:0]        ARID_M,
  input  logic [NM-1:0]            ARVALID_M,
  output logic [NM-1:0]            ARREADY_M,
  input  logic [NM-1:0]            RREADY_M,
  output logic [NM-1:0]            RVALID_M,
  output logic [31:0]              RDATA_M,
  output logic [IDW-1:0]           RID_M,
  output logic [1:0]               RRESP_M,
  output logic                     RLAST_M,
  output logic [31:0]              ARADDR_S,
  output logic [3:0]               ARLEN_S,
  output logic [IDW+3:0]           ARID_S,
  output logic [NS-1:0]            ARVALID_S,
  input  logic [NS-1:0]            ARREADY_S,
  input  logic [NS*32-1:0]         RDATA_S,
  input  logic [NS*2-1:0]          RRESP_S,
  input  logic [NS*(IDW+4)-1:0]    RID_S,
  input  logic [NS-1:0]            RLAST_S,
  input  logic [NS-1:0]            RVALID_S,
  output logic [NS-1:0]            RREADY_S,
  output logic                     rd_busy,
  output logic                     len_err
);

  rd_state_e r_state;
  rd_state_e w_state_nxt;

  logic [AR_M_BITS-1:0] r_m;
  logic [AR_S_BITS-1:0] r_s;
  logic [3:0]           r_len;
  logic [IDW-1:0]       r_id;
  logic [31:0]          r_addr;
  logic [3:0]           r_cnt;
  logic                 r_len_err;

  ar_grant_t            w_grant;
  logic                 w_grant_valid;

  logic [31:0]          w_m_addr;
  logic [3:0]           w_m_len;
  logic [IDW-1:0]       w_m_id;
  logic                 w_m_rready;

  logic                 w_s_arready;
  logic                 w_s_rvalid;
  logic                 w_s_rlast;
  logic [31:0]          w_s_rdata;
  logic [1:0]           w_s_rresp;
  logic [IDW-1:0]       w_s_rid;

  logic                 w_r_hs;
  logic                 w_last_beat;

  logic                 w_de_rvalid;
  logic                 w_de_rlast;
  logic                 w_de_done;
  logic [31:0]          w_de_rdata;
  logic [1:0]           w_de_rresp;

  // Master AR valid is implied by the grant; upper slave RID bits carry the
  // master index, which the route already knows.
  logic                 w_unused;
  assign w_unused = ^{ARVALID_M, RID_S};

  assign w_grant       = ar_decode(AR_arbiter);
  assign w_grant_valid = (AR_arbiter != AR_DEFAULT_R);
  assign w_last_beat   = (r_cnt == r_len);
  assign w_r_hs        = (r_state == ST_DATA) && w_s_rvalid && w_m_rready;
  assign rd_busy       = (r_state != ST_IDLE);
  assign len_err       = r_len_err;

  // Select the granted master's AR payload for latching in IDLE.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch;
    // leaving a path unassigned would infer a latch.
    w_m_addr = '0;
    w_m_len  = '0;
    w_m_id   = '0;
    for (int i = 0; i < NM; i++) begin
      if (w_grant.master == AR_M_BITS'(i)) begin
        w_m_addr = ARADDR_M[i*32 +: 32];
        w_m_len  = ARLEN_M[i*4 +: 4];
        w_m_id   = ARID_M[i*IDW +: IDW];
      end
    end
  end

  // Select the routed master's R ready.
  always_comb begin
    w_m_rready = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (r_m == AR_M_BITS'(i)) w_m_rready = RREADY_M[i];
    end
  end

  // Select the routed slave's AR ready and R channel.
  always_comb begin
    w_s_arready = 1'b0;
    w_s_rvalid  = 1'b0;
    w_s_rlast   = 1'b0;
    w_s_rdata   = '0;
    w_s_rresp   = '0;
    w_s_rid     = '0;
    for (int j = 0; j < NS; j++) begin
      if (r_s == AR_S_BITS'(j)) begin
        w_s_arready = ARREADY_S[j];
        w_s_rvalid  = RVALID_S[j];
        w_s_rlast   = RLAST_S[j];
        w_s_rdata   = RDATA_S[j*32 +: 32];
        w_s_rresp   = RRESP_S[j*2 +: 2];
        w_s_rid     = RID_S[j*(IDW+4) +: IDW];
      end
    end
  end

  axi_rd_decerr_slave u_decerr (
    .clk      (ACLK),
    .rst_n    (ARESETn),
    .i_start  (r_state == ST_ERR_ADDR),
    .i_active (r_state == ST_ERR_DATA),
    .i_len    (r_len),
    .i_rready (w_m_rready),
    .o_rvalid (w_de_rvalid),
    .o_rlast  (w_de_rlast),
    .o_done   (w_de_done),
    .o_rdata  (w_de_rdata),
    .o_rresp  (w_de_rresp)
  );

  // Next-state logic: one outstanding read, held until its last beat.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:     if (w_grant_valid) w_state_nxt = w_grant.hit ? ST_ADDR : ST_ERR_ADDR;
      ST_ADDR:     if (w_s_arready) w_state_nxt = ST_DATA;
      ST_DATA:     if (w_r_hs && w_last_beat) w_state_nxt = ST_IDLE;
      ST_ERR_ADDR: w_state_nxt = ST_ERR_DATA;
      ST_ERR_DATA: if (w_de_done) w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Route and payload latch, captured once per grant while IDLE.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: these are plain registers, not a memory, so resetting them is
    // cheap and keeps the first ADDR cycle after reset deterministic.
    if (!ARESETn) begin
      r_m    <= '0;
      r_s    <= '0;
      r_len  <= '0;
      r_id   <= '0;
      r_addr <= '0;
    end else if (r_state == ST_IDLE && w_grant_valid) begin
      r_m    <= w_grant.master;
      r_s    <= w_grant.slave;
      r_len  <= w_m_len;
      r_id   <= w_m_id;
      r_addr <= w_m_addr;
    end
  end

  // Beat counter for mapped bursts; holds on the last beat so it never wraps.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_cnt <= '0;
    end else if (r_state == ST_ADDR && w_s_arready) begin
      r_cnt <= '0;
    end else if (w_r_hs && !w_last_beat) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  // Sticky flag: slave RLAST disagrees with the beat count on an accepted beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_len_err <= 1'b0;
    end else if (w_r_hs && (w_s_rlast != w_last_beat)) begin
      r_len_err <= 1'b1;
    end
  end

  // Channel routing: only the granted master and selected slave lanes move.
  always_comb begin
    ARREADY_M = '0;
    RVALID_M  = '0;
    RDATA_M   = '0;
    RID_M     = '0;
    RRESP_M   = RESP_OKAY;
    RLAST_M   = 1'b0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARID_S    = '0;
    ARVALID_S = '0;
    RREADY_S  = '0;
    unique case (r_state)
      ST_ADDR: begin
        ARVALID_S[r_s] = 1'b1;
        ARADDR_S       = r_addr;
        ARLEN_S        = r_len;
        ARID_S         = {4'(r_m), r_id};
        ARREADY_M[r_m] = w_s_arready;
      end
      ST_ERR_ADDR: begin
        ARREADY_M[r_m] = 1'b1;
      end
      ST_DATA: begin
        RVALID_M[r_m] = w_s_rvalid;
        RREADY_S[r_s] = w_m_rready;
        RDATA_M       = w_s_rdata;
        RRESP_M       = w_s_rresp;
        RID_M         = w_s_rid;
        RLAST_M       = w_last_beat;
      end
      ST_ERR_DATA: begin
        RVALID_M[r_m] = w_de_rvalid;
        RDATA_M       = w_de_rdata;
        RRESP_M       = w_de_rresp;
        RID_M         = r_id;
        RLAST_M       = w_de_rlast;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_read_path_ctrl.sv
// Self-checking bench for axi_read_path_ctrl: the bench plays arbiter,
// masters and slaves, and predicts every beat from a per-burst queue model.
module tb_axi_read_path_ctrl;
  import axi_rd_pkg::*;

  localparam int NM   = 3;
  localparam int NS   = 8;
  localparam int IDW  = 4;
  localparam int SIDW = IDW + 4;

  logic                     ACLK = 1'b0;
  logic                     ARESETn = 1'b0;
  logic [MX_SX_ID_BITS-1:0] AR_arbiter;
  logic [NM*32-1:0]         ARADDR_M;
  logic [NM*4-1:0]          ARLEN_M;
  logic [NM*IDW-1:0]        ARID_M;
  logic [NM-1:0]            ARVALID_M;
  logic [NM-1:0]            ARREADY_M;
  logic [NM-1:0]            RREADY_M;
  logic [NM-1:0]            RVALID_M;
  logic [31:0]              RDATA_M;
  logic [IDW-1:0]           RID_M;
  logic [1:0]               RRESP_M;
  logic                     RLAST_M;
  logic [31:0]              ARADDR_S;
  logic [3:0]               ARLEN_S;
  logic [SIDW-1:0]          ARID_S;
  logic [NS-1:0]            ARVALID_S;
  logic [NS-1:0]            ARREADY_S;
  logic [NS*32-1:0]         RDATA_S;
  logic [NS*2-1:0]          RRESP_S;
  logic [NS*SIDW-1:0]       RID_S;
  logic [NS-1:0]            RLAST_S;
  logic [NS-1:0]            RVALID_S;
  logic [NS-1:0]            RREADY_S;
  logic                     rd_busy;
  logic                     len_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_len_err = 1'b0;

  always #5 ACLK = ~ACLK;

  axi_read_path_ctrl #(.NM(NM), .NS(NS), .IDW(IDW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .AR_arbiter(AR_arbiter),
    .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARID_M(ARID_M),
    .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RREADY_M(RREADY_M), .RVALID_M(RVALID_M), .RDATA_M(RDATA_M),
    .RID_M(RID_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARID_S(ARID_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RID_S(RID_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .rd_busy(rd_busy), .len_err(len_err)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Random traffic on every slave lane and master R ready.
  task automatic scramble_slaves();
    for (int j = 0; j < NS; j++) begin
      RDATA_S[j*32 +: 32]  = $urandom;
      RRESP_S[j*2 +: 2]    = 2'($urandom);
      RID_S[j*SIDW +: SIDW] = SIDW'($urandom);
    end
    RLAST_S   = NS'($urandom);
    RVALID_S  = NS'($urandom);
    ARREADY_S = NS'($urandom);
    RREADY_M  = NM'($urandom);
  endtask

  task automatic scramble_masters();
    for (int i = 0; i < NM; i++) begin
      ARADDR_M[i*32 +: 32] = $urandom;
      ARLEN_M[i*4 +: 4]    = 4'($urandom);
      ARID_M[i*IDW +: IDW] = IDW'($urandom);
    end
    ARVALID_M = NM'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_arready_m"}, ARREADY_M, 0);
    check({tag, "_rvalid_m"},  RVALID_M, 0);
    check({tag, "_rdata_m"},   RDATA_M, 0);
    check({tag, "_rid_m"},     RID_M, 0);
    check({tag, "_rresp_m"},   RRESP_M, 0);
    check({tag, "_rlast_m"},   RLAST_M, 0);
    check({tag, "_araddr_s"},  ARADDR_S, 0);
    check({tag, "_arlen_s"},   ARLEN_S, 0);
    check({tag, "_arid_s"},    ARID_S, 0);
    check({tag, "_arvalid_s"}, ARVALID_S, 0);
    check({tag, "_rready_s"},  RREADY_S, 0);
    check({tag, "_busy"},      rd_busy, 0);
    check({tag, "_len_err"},   len_err, 0);
  endtask

  // One idle cycle with every slave offering a beat: nothing may be routed.
  task automatic check_idle();
    @(negedge ACLK);
    AR_arbiter = AR_DEFAULT_R;
    scramble_slaves();
    RVALID_S = '1;
    RREADY_M = '1;
    #1;
    check("idle_busy",      rd_busy, 0);
    check("idle_rvalid_m",  RVALID_M, 0);
    check("idle_rready_s",  RREADY_S, 0);
    check("idle_arvalid_s", ARVALID_S, 0);
    check("idle_arready_m", ARREADY_M, 0);
    check("idle_len_err",   len_err, exp_len_err);
  endtask

  // One complete read. sl < 0 means unmapped. rmode: 0 random handshakes,
  // 1 RREADY pattern 1-0-0-1, 2 always ready. abort_after >= 0 drops reset
  // once that many beats have been accepted.
  task automatic do_read(input int m, input int sl, input logic [31:0] addr,
                         input int len, input logic [IDW-1:0] id,
                         input int rlast_at, input int rmode, input int abort_after);
    logic [31:0]              data_q[$];
    logic [1:0]               resp_q[$];
    logic [MX_SX_ID_BITS-1:0] code;
    logic [SIDW-1:0]          exp_sid;
    logic [3:0]               pat;
    bit                       mapped;
    bit                       done;
    bit                       vs;
    bit                       rr;
    int                       b;
    int                       cyc;

    pat     = 4'b1001;
    mapped  = (sl >= 0);
    code    = {2'(m), mapped ? 4'(sl) : AR_SLAVE_NO};
    exp_sid = {4'(m), id};
    for (int k = 0; k <= len; k++) begin
      data_q.push_back($urandom);
      resp_q.push_back(($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00);
    end

    // Grant cycle: the DUT is idle and latches at the next edge.
    @(negedge ACLK);
    scramble_masters();
    scramble_slaves();
    ARADDR_M[m*32 +: 32] = addr;
    ARLEN_M[m*4 +: 4]    = 4'(len);
    ARID_M[m*IDW +: IDW] = id;
    AR_arbiter           = code;
    #1;
    check("grant_busy", rd_busy, 0);

    // Address phase. Master payloads are scrambled to prove they were latched.
    @(negedge ACLK);
    AR_arbiter = AR_DEFAULT_R;
    scramble_masters();
    if (mapped) begin
      done = 1'b0;
      cyc  = 0;
      while (!done) begin
        if (cyc > 0) @(negedge ACLK);
        ARREADY_S     = NS'($urandom);
        ARREADY_S[sl] = (cyc >= 3 || rmode != 0) ? 1'b1 : 1'($urandom_range(0, 1));
        #1;
        check("ar_valid_s", ARVALID_S, 64'(1) << sl);
        check("ar_addr_s",  ARADDR_S, addr);
        check("ar_len_s",   ARLEN_S, len);
        check("ar_id_s",    ARID_S, exp_sid);
        check("ar_ready_m", ARREADY_M, ARREADY_S[sl] ? (64'(1) << m) : 64'(0));
        check("ar_busy",    rd_busy, 1);
        done = ARREADY_S[sl];
        cyc++;
      end
    end else begin
      ARREADY_S = '1;
      #1;
      check("err_ar_ready_m", ARREADY_M, 64'(1) << m);
      check("err_ar_valid_s", ARVALID_S, 0);
    end

    // Data phase: the model beat index b advances only on an R handshake.
    b    = 0;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge ACLK);
      scramble_slaves();
      ARREADY_S = '1;
      vs = (mapped && rmode == 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
      case (rmode)
        0:       rr = ($urandom_range(0, 2) != 0);
        1:       rr = pat[cyc % 4];
        default: rr = 1'b1;
      endcase
      if (cyc >= 40 && rmode == 0) begin
        vs = 1'b1;
        rr = 1'b1;
      end
      if (mapped) begin
        RDATA_S[sl*32 +: 32]   = data_q[b];
        RRESP_S[sl*2 +: 2]     = resp_q[b];
        RID_S[sl*SIDW +: SIDW] = exp_sid;
        RLAST_S[sl]            = (b == rlast_at);
        RVALID_S[sl]           = vs;
      end
      RREADY_M[m] = rr;

      if (abort_after >= 0 && b == abort_after) begin
        #1;
        ARESETn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_len_err = 1'b0;
        @(negedge ACLK);
        ARESETn = 1'b1;
        check_idle();
        return;
      end

      #1;
      check("r_valid_m",  RVALID_M, vs ? (64'(1) << m) : 64'(0));
      check("r_ready_s",  RREADY_S, (mapped && rr) ? (64'(1) << sl) : 64'(0));
      check("r_arvalid",  ARVALID_S, 0);
      check("r_arready",  ARREADY_M, 0);
      check("r_busy",     rd_busy, 1);
      if (vs) begin
        check("r_data", RDATA_M, mapped ? data_q[b] : 32'h0);
        check("r_resp", RRESP_M, mapped ? resp_q[b] : RESP_DECERR);
        check("r_id",   RID_M, id);
        check("r_last", RLAST_M, (b == len));
      end
      if (vs && rr) begin
        if (b == len) done = 1'b1;
        b++;
      end
      cyc++;
      if (!done && cyc >= 400) begin
        check("data_budget", b, len + 1);
        done = 1'b1;
      end
    end

    if (mapped && rlast_at != len) exp_len_err = 1'b1;
    check_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    AR_arbiter = 6'h05;
    ARADDR_M   = '0;
    ARLEN_M    = '0;
    ARID_M     = '0;
    ARVALID_M  = '0;
    scramble_slaves();
    #1;
    check_all_zero("reset");
    @(negedge ACLK);
    ARESETn    = 1'b1;
    AR_arbiter = AR_DEFAULT_R;
    check_idle();

    // Mapped read from IM, 4 beats.
    do_read(0, int'(S_IM), 32'h0001_0040, 3, 4'h5, 3, 2, -1);
    // Unmapped read, 2 DECERR beats.
    do_read(1, -1, 32'h0500_0000, 1, 4'hA, 1, 2, -1);
    // DRAM burst under RREADY 1-0-0-1 backpressure.
    do_read(2, int'(S_DRAM), $urandom, 7, 4'h3, 7, 1, -1);
    // Early slave RLAST on beat 1 of 4.
    do_read(0, int'(S_DM), $urandom, 3, 4'h7, 1, 2, -1);
    // Late slave RLAST: never asserted within the burst.
    do_read(1, int'(S_EPU), $urandom, 2, 4'h9, 4, 2, -1);
    // Reset after 2 of 4 beats, then a clean read.
    do_read(2, int'(S_ROM), $urandom, 3, 4'hC, 3, 2, 2);
    do_read(2, int'(S_ROM), $urandom, 3, 4'hD, 3, 2, -1);
    // Full-length bursts, mapped and unmapped.
    do_read(1, int'(S_DRAM), $urandom, 15, 4'h1, 15, 0, -1);
    do_read(0, -1, $urandom, 15, 4'hE, 15, 0, -1);

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      int m;
      int sl;
      int len;
      int rl;
      m   = $urandom_range(0, NM - 1);
      sl  = $urandom_range(0, 9);
      if (sl >= NS) sl = -1;
      len = $urandom_range(0, 15);
      rl  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : len;
      do_read(m, sl, $urandom, len, IDW'($urandom), rl, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
